// File: rtl/lighthouse_timer.sv
// ---------------------------------------------------------------------------
// lighthouse_timer
//
// Timestamps Lighthouse optical pulses seen by one photodiode front end.
// The active-low envelope is synchronised and edge-detected. Each low pulse
// is measured and classified by width:
//   - glitch : width < GLITCH_MIN_CLKS, dropped
//   - sync   : width >= SYNC_MIN_CLKS
//   - sweep  : anything in between
// One timing record is published per base-station cycle.
//
// Ports
//   i_clk          system clock, all logic on posedge (16 MHz in target)
//   i_rst_n        synchronous active-low reset
//   i_envelope     async active-low light envelope (low = light present)
//   i_data         async demodulated laser bitstream, unused this revision
//   o_sync_A_time  free-running clk count at sync A start
//   o_sync_B_time  clks from sync A start to sync B start, 0 = no sync B
//   o_sweep_time   clks from sync A start to sweep start, 0 = sweep missing
//   o_complete     1-clk strobe: the three outputs hold a new record
// ---------------------------------------------------------------------------
module lighthouse_timer #(
  parameter logic [31:0] SYNC_MIN_CLKS      = 32'd800,
  parameter logic [31:0] GLITCH_MIN_CLKS    = 32'd4,
  parameter logic [31:0] CYCLE_TIMEOUT_CLKS = 32'd128000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_envelope,
  input  logic        i_data,
  output logic [31:0] o_sync_A_time,
  output logic [31:0] o_sync_B_time,
  output logic [31:0] o_sweep_time,
  output logic        o_complete
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CYCLE   = 2'd1,
    ST_CYCLE_B = 2'd2
  } state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Synchroniser and edge-detect history. Reset to 1 (dark) so that coming
  // out of reset never fakes a falling edge.
  logic        r_env_meta;
  logic        r_env_sync;
  logic        r_env_prev;

  logic [31:0] r_timestamp;
  logic [31:0] r_elapsed;

  // Open-pulse bookkeeping.
  logic        r_in_pulse;
  logic [31:0] r_width;
  logic [31:0] r_start_ts;
  logic [31:0] r_start_el;

  // Pending record for the cycle in flight.
  state_t      r_state;
  logic [31:0] r_rec_a;
  logic [31:0] r_rec_b;

  logic        w_fall;
  logic        w_rise;
  logic        w_valid;
  logic        w_sync;
  logic        w_sweep;
  logic        w_timeout;
  logic        w_start_cycle;
  logic [31:0] w_rebase_el;
  logic        w_unused_data;

  assign w_unused_data = i_data;

  assign w_fall  = r_env_prev & ~r_env_sync;
  assign w_rise  = ~r_env_prev & r_env_sync & r_in_pulse;
  assign w_valid = w_rise & (r_width >= GLITCH_MIN_CLKS);
  assign w_sync  = w_valid & (r_width >= SYNC_MIN_CLKS);
  assign w_sweep = w_valid & (r_width < SYNC_MIN_CLKS);

  // Timeout only counts while the envelope is dark, so a pulse spanning the
  // deadline gets classified first on its rising edge.
  assign w_timeout = (r_elapsed >= CYCLE_TIMEOUT_CLKS) & r_env_sync;

  // A sync is only known to be sync A at its rising edge, so elapsed is
  // rebased to "now minus sync start" rather than cleared at the falling
  // edge. The +1 accounts for the value being loaded for the next clock.
  assign w_rebase_el = r_timestamp + 32'd1 - r_start_ts;

  // Decide whether this clock's pulse opens a new cycle (new sync A).
  always_comb begin
    w_start_cycle = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_cycle = w_sync;
      end
      ST_CYCLE_B: begin
        w_start_cycle = w_sync;
      end
      default: begin
        w_start_cycle = 1'b0;
      end
    endcase
  end

  // Synchroniser, free-running timestamp, elapsed counter and pulse capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_env_meta  <= 1'b1;
      r_env_sync  <= 1'b1;
      r_env_prev  <= 1'b1;
      r_timestamp <= 32'd0;
      r_elapsed   <= 32'd0;
      r_in_pulse  <= 1'b0;
      r_width     <= 32'd0;
      r_start_ts  <= 32'd0;
      r_start_el  <= 32'd0;
    end else begin
      r_env_meta  <= i_envelope;
      r_env_sync  <= r_env_meta;
      r_env_prev  <= r_env_sync;
      r_timestamp <= r_timestamp + 32'd1;

      if (w_start_cycle) begin
        r_elapsed <= w_rebase_el;
      end else begin
        r_elapsed <= sat_inc(r_elapsed);
      end

      if (w_fall) begin
        r_in_pulse <= 1'b1;
        r_width    <= 32'd1;
        r_start_ts <= r_timestamp;
        r_start_el <= r_elapsed;
      end else if (w_rise) begin
        r_in_pulse <= 1'b0;
      end else if (r_in_pulse) begin
        r_width <= sat_inc(r_width);
      end
    end
  end

  // Cycle FSM with registered record outputs and completion strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_rec_a       <= 32'd0;
      r_rec_b       <= 32'd0;
      o_sync_A_time <= 32'd0;
      o_sync_B_time <= 32'd0;
      o_sweep_time  <= 32'd0;
      o_complete    <= 1'b0;
    end else begin
      o_complete <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Sweeps and glitches with no open cycle are dropped.
          if (w_sync) begin
            r_rec_a <= r_start_ts;
            r_rec_b <= 32'd0;
            r_state <= ST_CYCLE;
          end
        end

        ST_CYCLE: begin
          if (w_sync) begin
            r_rec_b <= r_start_el;
            r_state <= ST_CYCLE_B;
          end else if (w_sweep) begin
            o_sync_A_time <= r_rec_a;
            o_sync_B_time <= r_rec_b;
            o_sweep_time  <= r_start_el;
            o_complete    <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (w_timeout) begin
            o_sync_A_time <= r_rec_a;
            o_sync_B_time <= r_rec_b;
            o_sweep_time  <= 32'd0;
            o_complete    <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_CYCLE_B: begin
          if (w_sync) begin
            // Third sync: close the old cycle without a sweep and let this
            // sync become sync A of the next one.
            o_sync_A_time <= r_rec_a;
            o_sync_B_time <= r_rec_b;
            o_sweep_time  <= 32'd0;
            o_complete    <= 1'b1;
            r_rec_a       <= r_start_ts;
            r_rec_b       <= 32'd0;
            r_state       <= ST_CYCLE;
          end else if (w_sweep) begin
            o_sync_A_time <= r_rec_a;
            o_sync_B_time <= r_rec_b;
            o_sweep_time  <= r_start_el;
            o_complete    <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (w_timeout) begin
            o_sync_A_time <= r_rec_a;
            o_sync_B_time <= r_rec_b;
            o_sweep_time  <= 32'd0;
            o_complete    <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_rec_a <= 32'd0;
          r_rec_b <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lighthouse_timer.sv
// ---------------------------------------------------------------------------
// tb_lighthouse_timer
//
// Scoreboard bench. Stimulus tasks drive envelope pulses. For each pulse, a
// cycle-level reference model (sync A time, optional sync B offset) predicts
// the records and pushes them into a queue. A negedge monitor pops one
// entry per o_complete strobe and compares it.
//
// Timing parameters are scaled by 1/10 from the 16 MHz values so the run
// stays short: SYNC_MIN 80, TIMEOUT 12800, period 13333, B +640,
// sweep +5568. GLITCH_MIN stays at 4.
// ---------------------------------------------------------------------------
module tb_lighthouse_timer;

  localparam longint T_SYNC   = 80;
  localparam longint T_GLITCH = 4;
  localparam longint T_TO     = 12800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        env;
  logic        data;
  logic [31:0] sync_a;
  logic [31:0] sync_b;
  logic [31:0] sweep;
  logic        complete;

  always #5 clk = ~clk;

  lighthouse_timer #(
    .SYNC_MIN_CLKS      (32'd80),
    .GLITCH_MIN_CLKS    (32'd4),
    .CYCLE_TIMEOUT_CLKS (32'd12800)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_envelope    (env),
    .i_data        (data),
    .o_sync_A_time (sync_a),
    .o_sync_B_time (sync_b),
    .o_sweep_time  (sweep),
    .o_complete    (complete)
  );

  // Clock count since reset: the timestamp definition used by the model.
  longint tb_ts;
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= 0;
    else        tb_ts <= tb_ts + 1;
  end

  typedef struct {
    longint a;
    longint b;
    longint s;
    longint t;
  } rec_t;

  rec_t   exp_q[$];
  rec_t   last_exp;
  longint seen_a[$];
  int     n_tests  = 0;
  int     n_fail   = 0;
  int     n_pushed = 0;
  int     n_seen   = 0;

  // Reference model: the open cycle (if any).
  bit     m_open  = 1'b0;
  bit     m_has_b = 1'b0;
  longint m_a     = 0;
  longint m_b     = 0;

  task automatic chk(input string name, input longint act, input longint expv, input longint tol);
    longint d;
    n_tests++;
    d = act - expv;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
    end
  endtask

  function automatic void push(input longint a, input longint b, input longint s, input longint t);
    rec_t r;
    r.a = a; r.b = b; r.s = s; r.t = t;
    exp_q.push_back(r);
    last_exp = r;
    n_pushed++;
  endfunction

  function automatic void m_timeout(input longint t);
    push(m_a, m_has_b ? m_b : 0, 0, t);
    m_open = 1'b0;
  endfunction

  function automatic void m_start(input longint f);
    m_open  = 1'b1;
    m_a     = f;
    m_has_b = 1'b0;
    m_b     = 0;
  endfunction

  // Wait n clocks with the envelope dark. A cycle times out in this window if
  // its deadline falls before the next possible falling edge is seen.
  task automatic idle(input int n);
    if (m_open && (m_a + T_TO < tb_ts + n + 2)) m_timeout(m_a + T_TO + 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      data = ($urandom_range(0, 1) == 1);
    end
  endtask

  // One low pulse of w clocks, then gap dark clocks. The front end sees the
  // edges two clocks after they are driven; the offsets do not depend on that.
  task automatic pulse(input int w, input int gap);
    longint f;
    longint r;
    f = tb_ts + 2;
    r = f + w;
    if (m_open && (m_a + T_TO < f)) m_timeout(m_a + T_TO + 1);
    if (w >= T_GLITCH) begin
      if (w >= T_SYNC) begin
        if (!m_open) m_start(f);
        else if (!m_has_b) begin
          m_has_b = 1'b1;
          m_b     = f - m_a;
        end else begin
          push(m_a, m_b, 0, r + 1);
          m_start(f);
        end
      end else if (m_open) begin
        push(m_a, m_has_b ? m_b : 0, f - m_a, r + 1);
        m_open = 1'b0;
      end
    end
    if (m_open && (m_a + T_TO <= r)) m_timeout(r + 2);
    env = 1'b0;
    repeat (w) @(posedge clk);
    #1;
    env = 1'b1;
    idle(gap);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sync_A"}, longint'(sync_a), 0, 0);
    chk({tag, "_sync_B"}, longint'(sync_b), 0, 0);
    chk({tag, "_sweep"}, longint'(sweep), 0, 0);
    chk({tag, "_complete"}, longint'(complete), 0, 0);
  endtask

  // Monitor: pop and compare one expected record per completion strobe.
  bit after_c = 1'b0;
  always @(negedge clk) begin : mon
    rec_t e;
    if (after_c) chk("complete_one_clk", longint'(complete), 0, 0);
    after_c = 1'b0;
    if (rst_n === 1'b1 && complete === 1'b1) begin
      n_seen++;
      seen_a.push_back(longint'(sync_a));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_complete: got record A=%0d B=%0d S=%0d, expected none",
                 sync_a, sync_b, sweep);
      end else begin
        e = exp_q.pop_front();
        chk("sync_A_time", longint'(sync_a), e.a, 1);
        chk("sync_B_time", longint'(sync_b), e.b, (e.b == 0) ? 0 : 1);
        chk("sweep_time", longint'(sweep), e.s, (e.s == 0) ? 0 : 1);
        chk("complete_time", tb_ts, e.t, 2);
      end
      after_c = 1'b1;
    end
  end

  initial begin
    #(10 * 300000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_before;
    int k;
    rst_n = 1'b0;
    env   = 1'b1;
    data  = 1'b0;
    last_exp = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(10);

    // Single sync cycle, then the next cycle's sync A one period later.
    pulse(160, 5568 - 160);
    pulse(16, 13333 - 5568 - 16);

    // Double sync cycle.
    pulse(160, 640 - 160);
    pulse(160, 5568 - 640 - 160);
    pulse(16, 2000);
    chk("records_after_two_cycles", seen_a.size(), 2, 0);
    if (seen_a.size() >= 2) chk("sync_A_period", seen_a[1] - seen_a[0], 13333, 1);

    // Missing sweep: the cycle closes on timeout.
    pulse(160, 640 - 160);
    pulse(160, 14000);

    // Glitches and orphan sweeps in IDLE: no record, outputs hold.
    seen_before = n_seen;
    pulse(2, 50);
    pulse(3, 50);
    pulse(79, 60);
    pulse(16, 60);
    chk("idle_no_complete", n_seen, seen_before, 0);
    chk("idle_hold_sync_A", longint'(sync_a), last_exp.a, 1);
    chk("idle_hold_sync_B", longint'(sync_b), last_exp.b, 1);
    chk("idle_hold_sweep", longint'(sweep), last_exp.s, 0);

    // Width boundaries: 80 is sync, 4 and 79 are sweeps.
    pulse(80, 300);
    pulse(80, 300);
    pulse(4, 300);
    pulse(160, 300);
    pulse(79, 300);

    // Three syncs: the third one opens the next cycle.
    pulse(160, 640 - 160);
    pulse(160, 2000 - 640 - 160);
    pulse(160, 5568 - 160);
    pulse(16, 300);

    // Reset mid-cycle discards the open record.
    pulse(160, 500);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero_outputs("midreset");
    m_open   = 1'b0;
    m_has_b  = 1'b0;
    last_exp = '{0, 0, 0, 0};
    rst_n = 1'b1;
    idle(20);
    pulse(160, 640 - 160);
    pulse(160, 5568 - 640 - 160);
    pulse(16, 300);

    // Randomised pulse train.
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2)      pulse($urandom_range(1, 3), $urandom_range(20, 1000));
      else if (k < 6) pulse($urandom_range(4, 79), $urandom_range(20, 1000));
      else            pulse($urandom_range(80, 300), $urandom_range(20, 1000));
    end

    // Let any open cycle time out, then confirm everything was seen.
    idle(int'(T_TO) + 100);
    chk("queue_drained", exp_q.size(), 0, 0);
    chk("record_count", n_seen, n_pushed, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
